// File: rtl/branch_sequencer.sv
// Branch sequencer: owns the condition-flag register and the program counter,
// tracks outstanding flag writes, and resolves conditional branches only once
// every in-flight flag writer has written back.
module branch_sequencer #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_issue,
  input  logic              flags_we,
  input  logic [5:0]        flags_in,
  input  logic              pc_advance,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic              br_control,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic [5:0]        flags_q,
  output logic [1:0]        pending,
  output logic              pend_full,
  output logic              stall,
  output logic              salto,
  output logic              flush,
  output logic              br_error
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  // Flush counter holds the number of flush cycles still to come after the
  // current one; entering FLUSH already accounts for the first cycle.
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [5:0]          flags_d;
  logic [1:0]          pend_q, pend_d;
  logic [3:0]          cond_q, cond_d;
  logic                ctrl_q, ctrl_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [2:0]          fcnt_q, fcnt_d;
  logic                salto_q, salto_d;
  logic                flush_q, flush_d;
  logic                err_q, err_d;
  logic                cond_legal;
  logic                taken;

  // Flag select restricted to the six architectural flags; illegal selects
  // read as 0 and are rejected separately.
  function automatic logic sel_flag(input logic [5:0] f, input logic [3:0] c);
    logic r;
    case (c)
      4'd0:    r = f[0];
      4'd1:    r = f[1];
      4'd2:    r = f[2];
      4'd3:    r = f[3];
      4'd4:    r = f[4];
      4'd5:    r = f[5];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign cond_legal = (cond_q <= 4'd5);
  assign taken      = ~(sel_flag(flags_q, cond_q) ^ ctrl_q);

  // Flag register and outstanding-write counter (saturating at 0 and 3).
  always_comb begin
    flags_d = flags_q;
    pend_d  = pend_q;
    if (flags_we) flags_d = flags_in;
    if (flag_issue && !flags_we && pend_q != 2'd3)
      pend_d = pend_q + 2'd1;
    else if (flags_we && !flag_issue && pend_q != 2'd0)
      pend_d = pend_q - 2'd1;
  end

  // Branch FSM next-state, PC update and registered pulse outputs.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cond_d   = cond_q;
    ctrl_d   = ctrl_q;
    target_d = target_q;
    fcnt_d   = fcnt_q;
    salto_d  = 1'b0;
    flush_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pc_advance) pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (br_valid) begin
          cond_d   = br_cond;
          ctrl_d   = br_control;
          target_d = br_target;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pend_q == 2'd0) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (!cond_legal) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (taken) begin
          pc_d    = target_q;
          salto_d = 1'b1;
          flush_d = 1'b1;
          fcnt_d  = FLUSH_LAST;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          fcnt_d  = fcnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and architectural state, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      flags_q <= 6'd0;
      pend_q  <= 2'd0;
      fcnt_q  <= 3'd0;
      salto_q <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      pend_q  <= pend_d;
      fcnt_q  <= fcnt_d;
      salto_q <= salto_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  // Latched branch request; only read after a fresh acceptance, so no reset.
  always_ff @(posedge clk) begin
    cond_q   <= cond_d;
    ctrl_q   <= ctrl_d;
    target_q <= target_d;
  end

  assign pc        = pc_q;
  assign pending   = pend_q;
  assign pend_full = (pend_q == 2'd3);
  assign br_ready  = (state_q == ST_IDLE);
  assign stall     = (state_q != ST_IDLE);
  assign salto     = salto_q;
  assign flush     = flush_q;
  assign br_error  = err_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a 16-bit instance for branch behaviour
// and a 4-bit instance sharing the same inputs for PC wrap-around.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_issue, flags_we, pc_advance, br_valid, br_control;
  logic [5:0]  flags_in;
  logic [3:0]  br_cond;
  logic [15:0] br_target;

  logic        br_ready, pend_full, stall, salto, flush, br_error;
  logic [15:0] pc;
  logic [5:0]  flags_q;
  logic [1:0]  pending;

  logic        br_ready_s, pend_full_s, stall_s, salto_s, flush_s, br_error_s;
  logic [3:0]  pc_s;
  logic [5:0]  flags_q_s;
  logic [1:0]  pending_s;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_pc;

  always #5 clk = ~clk;

  branch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .flag_issue(flag_issue), .flags_we(flags_we),
    .flags_in(flags_in), .pc_advance(pc_advance), .br_valid(br_valid),
    .br_ready(br_ready), .br_cond(br_cond), .br_control(br_control),
    .br_target(br_target), .pc(pc), .flags_q(flags_q), .pending(pending),
    .pend_full(pend_full), .stall(stall), .salto(salto), .flush(flush),
    .br_error(br_error)
  );

  branch_sequencer #(.ADDR_W(4), .RESET_PC(4'h0), .FLUSH_CYCLES(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .flag_issue(flag_issue), .flags_we(flags_we),
    .flags_in(flags_in), .pc_advance(pc_advance), .br_valid(br_valid),
    .br_ready(br_ready_s), .br_cond(br_cond), .br_control(br_control),
    .br_target(br_target[3:0]), .pc(pc_s), .flags_q(flags_q_s),
    .pending(pending_s), .pend_full(pend_full_s), .stall(stall_s),
    .salto(salto_s), .flush(flush_s), .br_error(br_error_s)
  );

  typedef struct {
    logic [3:0] cond;
    logic       ctrl;
    logic       exp_taken;
    logic       exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Branch with pending=0; pc_advance is held through the accept, WAIT and
  // RESOLVE edges: it counts only at the accept edge.
  task automatic run_branch(input logic [3:0] cond, input logic ctrl,
                            input logic exp_taken, input logic exp_err);
    br_valid   = 1'b1;
    br_cond    = cond;
    br_control = ctrl;
    br_target  = 16'h0040;
    pc_advance = 1'b1;
    tick();                                    // edge E
    br_valid = 1'b0;
    exp_pc   = exp_pc + 16'd1;
    chk("accept_pc", 32'(pc), 32'(exp_pc));
    chk("wait_stall", 32'(stall), 32'd1);
    chk("wait_ready", 32'(br_ready), 32'd0);
    tick();                                    // edge E+1
    chk("resolve_salto", 32'(salto), 32'd0);
    tick();                                    // edge E+2
    pc_advance = 1'b0;
    if (exp_taken) exp_pc = 16'h0040;
    chk("br_salto", 32'(salto), 32'(exp_taken));
    chk("br_error", 32'(br_error), 32'(exp_err));
    chk("br_flush", 32'(flush), 32'(exp_taken));
    chk("br_pc", 32'(pc), 32'(exp_pc));
    chk("br_ready_e2", 32'(br_ready), 32'(!exp_taken));
    tick();                                    // edge E+3
    chk("salto_pulse", 32'(salto), 32'd0);
    chk("err_pulse", 32'(br_error), 32'd0);
    chk("flush_e3", 32'(flush), 32'(exp_taken));
    if (exp_taken) begin
      tick();                                  // edge E+4
      chk("flush_end", 32'(flush), 32'd0);
      chk("ready_back", 32'(br_ready), 32'd1);
      chk("pc_hold", 32'(pc), 32'h40);
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{4'd1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'd2, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{4'd3, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'd4, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{4'd5, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'd1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{4'd2, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'd3, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'd4, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd5, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{4'd8, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{4'd15, 1'b0, 1'b0, 1'b1};

    // Reset with every write-type input active.
    rst_n = 1'b0; flag_issue = 1'b1; flags_we = 1'b1; flags_in = 6'h3F;
    pc_advance = 1'b1; br_valid = 1'b1; br_cond = 4'd0; br_control = 1'b1;
    br_target = 16'h0040;
    tick(); tick();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_pulses", {29'd0, salto, flush, br_error}, 32'd0);
    chk("rst_s_pc", 32'(pc_s), 32'd0);
    chk("rst_s_misc", {24'd0, flags_q_s, pending_s}, 32'd0);
    chk("rst_s_pulses", {27'd0, pend_full_s, stall_s, salto_s, flush_s, br_error_s}, 32'd0);
    rst_n = 1'b1; flag_issue = 1'b0; flags_we = 1'b0; flags_in = 6'h00;
    pc_advance = 1'b0; br_valid = 1'b0;
    tick();
    chk("post_rst_ready", 32'(br_ready), 32'd1);
    chk("post_rst_stall", 32'(stall), 32'd0);
    chk("post_rst_ready_s", 32'(br_ready_s), 32'd1);

    // PC advance and 4-bit wrap: 14 advances, then 15, 0, 1.
    pc_advance = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("pc_s_14", 32'(pc_s), 32'd14);
    tick(); chk("pc_s_15", 32'(pc_s), 32'd15);
    tick(); chk("pc_s_wrap0", 32'(pc_s), 32'd0);
    tick(); chk("pc_s_wrap1", 32'(pc_s), 32'd1);
    pc_advance = 1'b0;
    exp_pc = 16'd17;
    chk("pc_17", 32'(pc), 32'(exp_pc));

    // Load flags 010101, then all conditions with both polarities.
    flags_we = 1'b1; flags_in = 6'b010101;
    tick();
    flags_we = 1'b0;
    chk("flags_load", 32'(flags_q), 32'b010101);
    chk("pend_we_at0", 32'(pending), 32'd0);
    for (int i = 0; i < 14; i++)
      run_branch(vecs[i].cond, vecs[i].ctrl, vecs[i].exp_taken, vecs[i].exp_err);

    // Flag hazard: two writers in flight, branch must wait for both.
    flags_we = 1'b1; flags_in = 6'b000000;
    tick();
    flags_we = 1'b0; flag_issue = 1'b1;
    tick(); tick();
    flag_issue = 1'b0;
    chk("haz_pending2", 32'(pending), 32'd2);
    pc_advance = 1'b1; br_valid = 1'b1; br_cond = 4'd0; br_control = 1'b1;
    tick();
    exp_pc = exp_pc + 16'd1;
    pc_advance = 1'b0; br_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("haz_hold_stall", 32'(stall), 32'd1);
      chk("haz_hold_salto", 32'(salto), 32'd0);
    end
    flags_we = 1'b1; flags_in = 6'b000000;
    tick();
    chk("haz_pending1", 32'(pending), 32'd1);
    flags_in = 6'b000001;
    tick();                                    // edge W
    flags_we = 1'b0;
    chk("haz_pending0", 32'(pending), 32'd0);
    chk("haz_w_salto", 32'(salto), 32'd0);
    tick();
    chk("haz_w1_salto", 32'(salto), 32'd0);
    chk("haz_w1_pc", 32'(pc), 32'(exp_pc));
    tick();
    chk("haz_salto", 32'(salto), 32'd1);
    chk("haz_pc", 32'(pc), 32'h40);
    exp_pc = 16'h0040;
    tick(); tick();
    chk("haz_ready", 32'(br_ready), 32'd1);

    // Counter saturation and simultaneous issue/write-back.
    flag_issue = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("cnt_sat", 32'(pending), 32'd3);
    chk("cnt_full", 32'(pend_full), 32'd1);
    flags_we = 1'b1; flags_in = 6'b100000;
    tick();
    chk("cnt_both", 32'(pending), 32'd3);
    chk("cnt_both_flags", 32'(flags_q), 32'b100000);
    flag_issue = 1'b0;
    tick(); chk("cnt_dec2", 32'(pending), 32'd2);
    chk("cnt_notfull", 32'(pend_full), 32'd0);
    tick(); tick();
    chk("cnt_dec0", 32'(pending), 32'd0);
    flags_in = 6'b000001;
    tick();
    flags_we = 1'b0;
    chk("cnt_floor", 32'(pending), 32'd0);
    chk("cnt_floor_flags", 32'(flags_q), 32'b000001);

    // Reset during FLUSH aborts the flush and reloads the PC.
    br_valid = 1'b1; br_cond = 4'd0; br_control = 1'b1; br_target = 16'h0077;
    tick();
    br_valid = 1'b0;
    tick(); tick();
    chk("rf_salto", 32'(salto), 32'd1);
    chk("rf_pc", 32'(pc), 32'h77);
    rst_n = 1'b0;
    tick();
    chk("rf_flush", 32'(flush), 32'd0);
    chk("rf_stall", 32'(stall), 32'd0);
    chk("rf_pc_reset", 32'(pc), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rf_ready", 32'(br_ready), 32'd1);

    // Reset during WAIT: no salto, no PC load afterwards.
    flags_we = 1'b1; flags_in = 6'b000001;
    tick();
    flags_we = 1'b0;
    br_valid = 1'b1; br_target = 16'h0055;
    tick();
    br_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("rw_salto", 32'(salto), 32'd0);
    chk("rw_pc", 32'(pc), 32'd0);
    chk("rw_ready", 32'(br_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
